// File: rtl/rgmii_rx_gmii_adapter_pkg.sv
// Shared ethernet definitions for the RGMII receive path: speed encodings,
// nibble assembler states and the in-band link status record.
package rgmii_rx_gmii_adapter_pkg;

   localparam logic [1:0] SPEED_10   = 2'b00;
   localparam logic [1:0] SPEED_100  = 2'b01;
   localparam logic [1:0] SPEED_1000 = 2'b10;

   typedef enum logic {
      ASM_LOW  = 1'b0,
      ASM_HIGH = 1'b1
   } asm_state_t;

   typedef struct packed {
      logic       link;
      logic [1:0] speed;
      logic       duplex;
   } inband_status_t;

   // Encoding 2'b11 is not defined by RGMII and is handled like gigabit.
   function automatic logic is_gig(input logic [1:0] speed);
      return (speed == SPEED_1000) || (speed == 2'b11);
   endfunction

   function automatic inband_status_t decode_status(input logic [3:0] nib);
      inband_status_t s;
      s.link   = nib[0];
      s.speed  = nib[2:1];
      s.duplex = nib[3];
      return s;
   endfunction

endpackage

// File: rtl/rgmii_rx_gmii_adapter_inband_status.sv
// In-band RGMII link status decoder: a value is accepted only after it has been
// seen on two consecutive plain-idle samples.
module rgmii_inband_status
   import rgmii_rx_gmii_adapter_pkg::*;
#(
   parameter bit en_p = 1'b1
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       sample_idle_i,
   input  logic [3:0] nibble_i,
   output logic       link_up_o,
   output logic [1:0] link_speed_o,
   output logic       full_duplex_o
);

   logic [3:0]     cand_q, cand_d;
   logic           cand_vld_q, cand_vld_d;
   inband_status_t status_q, status_d;

   always_comb begin
      cand_d     = cand_q;
      cand_vld_d = cand_vld_q;
      status_d   = status_q;
      if (en_p) begin
         // Frame and carrier-extend samples break the run of matching idles.
         if (sample_idle_i) begin
            cand_d     = nibble_i;
            cand_vld_d = 1'b1;
            if (cand_vld_q && (cand_q == nibble_i)) begin
               status_d = decode_status(nibble_i);
            end
         end else begin
            cand_vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cand_q     <= 4'h0;
         cand_vld_q <= 1'b0;
         status_q   <= '0;
      end else begin
         cand_q     <= cand_d;
         cand_vld_q <= cand_vld_d;
         status_q   <= status_d;
      end
   end

   assign link_up_o     = status_q.link;
   assign link_speed_o  = status_q.speed;
   assign full_duplex_o = status_q.duplex;

endmodule

// File: rtl/rgmii_rx_gmii_adapter.sv
// Converts DDR-sampled RGMII receive nibbles into a GMII byte stream with a
// byte strobe; gigabit uses both edges, 10/100 assembles two rising-edge nibbles.
module rgmii_rx_gmii_adapter
   import rgmii_rx_gmii_adapter_pkg::*;
#(
   parameter bit inband_en_p = 1'b1
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic [4:0] ddr_q1_i,
   input  logic [4:0] ddr_q2_i,
   input  logic [1:0] speed_i,
   output logic [7:0] gmii_rxd_o,
   output logic       gmii_rx_dv_o,
   output logic       gmii_rx_er_o,
   output logic       gmii_ce_o,
   output logic       link_up_o,
   output logic [1:0] link_speed_o,
   output logic       full_duplex_o
);

   logic [1:0] mode_q, mode_d;
   asm_state_t state_q, state_d;
   logic [3:0] nib_lo_q, nib_lo_d;
   logic       ctl_lo_q, ctl_lo_d;
   logic       prev_ctl_q;
   logic       sync_q;
   logic [7:0] rxd_q, rxd_d;
   logic       dv_q, dv_d;
   logic       er_q, er_d;
   logic       ce_q, ce_d;

   logic ctl;
   logic ctl_rise;
   logic sample_idle;

   assign ctl      = ddr_q1_i[4];
   assign ctl_rise = ctl && !prev_ctl_q;

   always_comb begin
      mode_d   = mode_q;
      state_d  = state_q;
      nib_lo_d = nib_lo_q;
      ctl_lo_d = ctl_lo_q;
      rxd_d    = rxd_q;
      dv_d     = dv_q;
      er_d     = er_q;
      ce_d     = 1'b0;

      // Speed is only re-sampled between frames so a frame never changes format.
      if (!dv_q && !(ctl && sync_q)) begin
         mode_d = speed_i;
      end

      if (is_gig(mode_q)) begin
         state_d = ASM_LOW;
         ce_d    = 1'b1;
         rxd_d   = {ddr_q2_i[3:0], ddr_q1_i[3:0]};
         dv_d    = ctl;
         er_d    = ctl ^ ddr_q2_i[4];
      end else if (ctl_rise || (state_q == ASM_LOW)) begin
         state_d  = ASM_HIGH;
         nib_lo_d = ddr_q1_i[3:0];
         ctl_lo_d = ctl;
      end else begin
         state_d = ASM_LOW;
         ce_d    = 1'b1;
         if (ctl_lo_q && !ctl) begin
            // Odd nibble count: flag the dangling low nibble as an errored byte.
            rxd_d = {4'h0, nib_lo_q};
            dv_d  = 1'b1;
            er_d  = 1'b1;
         end else if (!ctl_lo_q && !ctl) begin
            rxd_d = 8'h00;
            dv_d  = 1'b0;
            er_d  = 1'b0;
         end else begin
            rxd_d = {ddr_q1_i[3:0], nib_lo_q};
            dv_d  = ctl_lo_q & ctl;
            er_d  = ctl_lo_q ^ ctl;
         end
      end

      // Until ctl has been seen low after reset we may be inside a frame tail.
      if (!sync_q) begin
         rxd_d = 8'h00;
         dv_d  = 1'b0;
         er_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mode_q     <= SPEED_10;
         state_q    <= ASM_LOW;
         nib_lo_q   <= 4'h0;
         ctl_lo_q   <= 1'b0;
         prev_ctl_q <= 1'b0;
         sync_q     <= 1'b0;
         rxd_q      <= 8'h00;
         dv_q       <= 1'b0;
         er_q       <= 1'b0;
         ce_q       <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         state_q    <= state_d;
         nib_lo_q   <= nib_lo_d;
         ctl_lo_q   <= ctl_lo_d;
         prev_ctl_q <= ctl;
         sync_q     <= sync_q | !ctl;
         rxd_q      <= rxd_d;
         dv_q       <= dv_d;
         er_q       <= er_d;
         ce_q       <= ce_d;
      end
   end

   assign gmii_rxd_o   = rxd_q;
   assign gmii_rx_dv_o = dv_q;
   assign gmii_rx_er_o = er_q;
   assign gmii_ce_o    = ce_q;

   assign sample_idle = is_gig(mode_q) ? (!ctl && !ddr_q2_i[4]) : !ctl;

   rgmii_inband_status #(
      .en_p (inband_en_p)
   ) u_inband_status (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .sample_idle_i (sample_idle),
      .nibble_i      (ddr_q1_i[3:0]),
      .link_up_o     (link_up_o),
      .link_speed_o  (link_speed_o),
      .full_duplex_o (full_duplex_o)
   );

endmodule

// File: doc/rgmii_rx_gmii_adapter.md
RGMII_RX_GMII_ADAPTER -- requirements
Module: rgmii_rx_gmii_adapter

Interface
REQ-001 SHALL have parameter inband_en_p, default 1, enabling in-band link-status decode.
REQ-002 SHALL have ports:
- clk_i  in  1  receive clock; same clock as the DDR input stage's output clock.
- reset_n_i  in  1  reset; asynchronous, active-low.
- ddr_q1_i  in  5  rising-edge sample {rx_ctl, rxd[3:0]}.
- ddr_q2_i  in  5  falling-edge sample {rx_ctl, rxd[3:0]}.
- speed_i  in  2  configured speed: 00=10M, 01=100M, 10=1G, 11 treated as 1G.
- gmii_rxd_o  out  8  assembled byte.
- gmii_rx_dv_o  out  1  data valid.
- gmii_rx_er_o  out  1  receive error.
- gmii_ce_o  out  1  byte strobe; GMII outputs are meaningful only when it is high.
- link_up_o  out  1  in-band link status.
- link_speed_o  out  2  in-band speed, same encoding as speed_i.
- full_duplex_o  out  1  in-band duplex.

Function
REQ-003 SHALL latch speed_i into an internal mode register only while no frame is active (dv low at output side); a speed change mid-frame SHALL take effect after the frame ends.
REQ-004 In 1G mode SHALL produce, every cycle: gmii_ce_o=1, rxd={q2[3:0],q1[3:0]}, dv=q1[4], er=q1[4]^q2[4]; latency 1 cycle from inputs to outputs.
REQ-005 In 10/100 mode SHALL use only ddr_q1_i, one nibble per cycle, with a two-state assembler: LOW (capture low nibble) -> HIGH (capture high nibble, emit byte).
REQ-006 10/100: the assembler SHALL be forced to LOW on the cycle q1[4] rises from 0, so the first nibble of a frame is the low nibble.
REQ-007 10/100: on HIGH SHALL emit rxd={nibble_hi,nibble_lo}, dv=ctl_lo&ctl_hi, er=ctl_lo^ctl_hi, with gmii_ce_o=1 for exactly one cycle, one cycle after the high nibble is sampled; gmii_ce_o=0 on every other cycle.
REQ-008 10/100: if ctl falls while in HIGH (odd nibble count), SHALL emit the partial byte with dv=1, er=1, upper nibble 0, then return to LOW.
REQ-009 10/100 idle (ctl low): gmii_ce_o SHALL keep pulsing every second cycle with dv=0, er=0, rxd=0.
REQ-010 When inband_en_p=1 and a sample has dv=0 and er=0 (1G: q1[4]=q2[4]=0; 10/100: ctl=0), SHALL decode rxd[0]=link, rxd[2:1]=speed, rxd[3]=duplex.
REQ-011 Status outputs SHALL update only after the same decoded value is seen on 2 consecutive idle samples; otherwise they hold.
REQ-012 Status SHALL NOT update during frames or carrier-extend/error idles (dv=0, er=1).
REQ-013 When inband_en_p=0, link_up_o, link_speed_o and full_duplex_o SHALL be held at reset values.

Reset
REQ-014 On reset_n_i low, SHALL asynchronously clear all outputs and state to 0: rxd=0, dv=0, er=0, ce=0, link_up=0, link_speed=00, full_duplex=0, assembler=LOW, mode register=speed_i sampled after release.
REQ-015 On reset deassertion mid-frame, SHALL emit dv=0 until the next rising ctl edge; no partial frame is emitted.

Structure
REQ-016 Speed encodings (SPEED_10/100/1000) and the assembler state enum SHALL reside in the shared ethernet package.
REQ-017 In-band status decode and 2-sample filtering SHALL be the sub-module rgmii_inband_status; nibble assembly stays in this module.

Verification
REQ-018 1G: q1=5'h1D, q2=5'h15 for 8 cycles -> gmii_rxd_o=8'h5D, dv=1, er=0, ce=1 each cycle, 1-cycle latency.
REQ-019 100M frame with nibbles 5,5,...,5,D (15×5, then D) -> 7 bytes 8'h55 followed by byte 8'hD5; ce high every 2nd cycle; first byte low nibble=5.
REQ-020 10M frame ending after 3 nibbles A,B,C -> byte 8'hBA (dv=1, er=0), then byte 8'h0C (dv=1, er=1).
REQ-021 Idle 1G: q1=q2=5'h0D twice -> link_up_o=1, link_speed_o=2'b10, full_duplex_o=1; a single glitch sample of 5'h00 -> outputs unchanged.
REQ-022 speed_i changed 1G->100M mid-frame -> remaining frame stays 1G format; 100M assembly begins after dv falls.
REQ-023 reset_n_i pulsed low during a 100M frame -> all outputs 0 immediately; dv stays 0 until the next ctl rising edge.
